// File: rtl/flop_r_pkg.sv
// ----------------------------------------------------------------------------
// flop_pkg
// Purpose : shared constants for the flop_r register family, used to reject
//           illegal parameter combinations at elaboration time.
// Contents: MAX_WIDTH, MAX_STAGES, param_in_range() helper.
// ----------------------------------------------------------------------------
package flop_pkg;

    localparam int MAX_WIDTH  = 1024;
    localparam int MAX_STAGES = 16;

    // Inclusive range test used by the elaboration-time parameter checks.
    function automatic bit param_in_range(input int val, input int lo, input int hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage : flop_pkg

// File: rtl/flop_r_if.sv
// ----------------------------------------------------------------------------
// flop_r_if
// Purpose : bundles the data path of a flop_r register (input word d and
//           registered output word q) so a producer/consumer pair can share it.
// Signals : d - data toward the register, WIDTH bits
//           q - registered data from the register, WIDTH bits
// Modports: master - drives d, observes q
//           slave  - receives d, drives q
// ----------------------------------------------------------------------------
interface flop_r_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    modport master (output d, input q);
    modport slave  (input d, output q);

endinterface : flop_r_if

// File: rtl/flop_r_stage.sv
// ----------------------------------------------------------------------------
// flop_r_stage
// Purpose : one WIDTH-bit D register with synchronous active-high reset.
// Ports   : i_clk   - rising-edge clock
//           i_reset - synchronous reset, loads RESET_VAL
//           i_d     - data input, WIDTH bits
//           o_q     - registered data output, WIDTH bits
// ----------------------------------------------------------------------------
module flop_r_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Stage register: reset wins, otherwise capture the input every edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : flop_r_stage

// File: rtl/flop_r.sv
// ----------------------------------------------------------------------------
// flop_r
// Purpose : parameterised synchronously reset D register; with STAGES > 1 it
//           forms a fixed-latency delay line of STAGES cascaded registers.
//           Free-running: no enable, no handshake.
// Params  : WIDTH     - data width, 1..1024
//           RESET_VAL - value loaded into every stage on reset
//           STAGES    - number of cascaded stages (= latency), 1..16
// Ports   : clk   - rising-edge clock
//           reset - synchronous active-high reset
//           d     - data input, WIDTH bits
//           q     - data output, straight from the last stage register
// ----------------------------------------------------------------------------
module flop_r
    import flop_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               STAGES    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (!param_in_range(WIDTH, 1, MAX_WIDTH)) begin : g_bad_width
        $error("flop_r: WIDTH=%0d outside 1..%0d", WIDTH, MAX_WIDTH);
    end
    if (!param_in_range(STAGES, 1, MAX_STAGES)) begin : g_bad_stages
        $error("flop_r: STAGES=%0d outside 1..%0d", STAGES, MAX_STAGES);
    end

    // w_chain[0] is the input, w_chain[i+1] is the output of stage i.
    logic [WIDTH-1:0] w_chain [0:STAGES];

    assign w_chain[0] = d;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        flop_r_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .i_clk   (clk),
            .i_reset (reset),
            .i_d     (w_chain[g]),
            .o_q     (w_chain[g+1])
        );
    end

    // q comes only from a register: no combinational path from d or reset.
    assign q = w_chain[STAGES];

`ifndef SYNTHESIS
    localparam logic [4:0] STAGES_CNT = 5'(STAGES);

    // Number of consecutive non-reset edges, saturating at STAGES; once it
    // saturates every stage holds real data rather than RESET_VAL.
    logic [4:0] r_clean_cnt;
    logic       r_seen_reset;

    // Track how long the pipeline has run without a reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clean_cnt <= 5'd0;
        end else if (r_clean_cnt != STAGES_CNT) begin
            r_clean_cnt <= r_clean_cnt + 5'd1;
        end else begin
            r_clean_cnt <= r_clean_cnt;
        end
    end

    // Remember that state has been initialised at least once.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seen_reset <= 1'b1;
        end else begin
            r_seen_reset <= r_seen_reset;
        end
    end

    a_reset_known : assert property (@(posedge clk) !$isunknown(reset))
        else $error("flop_r: reset is X at clock edge");

    a_reset_loads : assert property (@(posedge clk) reset |=> (q == RESET_VAL))
        else $error("flop_r: q != RESET_VAL after reset edge");

    a_latency : assert property (@(posedge clk)
        (r_seen_reset && (r_clean_cnt == STAGES_CNT)) |-> (q == $past(d, STAGES)))
        else $error("flop_r: q does not match d delayed by STAGES");

    a_q_known : assert property (@(posedge clk) r_seen_reset |-> !$isunknown(q))
        else $error("flop_r: q is X after reset");
`endif

endmodule : flop_r

// File: tb/tb_flop_r.sv
// ----------------------------------------------------------------------------
// tb_flop_r
// Purpose : self-checking bench for flop_r. Four instances with different
//           WIDTH / RESET_VAL / STAGES run side by side; a history-based
//           model predicts q from the recorded d and reset samples.
// ----------------------------------------------------------------------------
module tb_flop_r;

    logic clk;
    logic rst_a, rst_b, rst_c, rst_d;

    int n_checks = 0;
    int n_errors = 0;

    // Recorded d/reset values at every rising edge, per instance.
    logic [31:0] hist_d [0:3][0:2047];
    bit          hist_r [0:3][0:2047];
    int          n_hist = 0;

    flop_r_if #(.WIDTH(8))  if_a ();
    flop_r_if #(.WIDTH(8))  if_b ();
    flop_r_if #(.WIDTH(32)) if_c ();
    flop_r_if #(.WIDTH(1))  if_d ();

    flop_r #(.WIDTH(8), .RESET_VAL(8'h00), .STAGES(1)) u_dut_a (
        .clk(clk), .reset(rst_a), .d(if_a.d), .q(if_a.q));
    flop_r #(.WIDTH(8), .RESET_VAL(8'hFF), .STAGES(1)) u_dut_b (
        .clk(clk), .reset(rst_b), .d(if_b.d), .q(if_b.q));
    flop_r #(.WIDTH(32), .RESET_VAL(32'h0), .STAGES(3)) u_dut_c (
        .clk(clk), .reset(rst_c), .d(if_c.d), .q(if_c.q));
    flop_r #(.WIDTH(1), .RESET_VAL(1'b1), .STAGES(2)) u_dut_d (
        .clk(clk), .reset(rst_d), .d(if_d.d), .q(if_d.q));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // q after the latest edge: RESET_VAL if any of the last stg edges was a
    // reset edge, otherwise the d that was sampled stg-1 edges ago.
    function automatic logic [31:0] model(input int idx, input int stg, input logic [31:0] rv);
        for (int j = 0; j < stg; j++) begin
            if ((n_hist - 1 - j) < 0) return rv;
            if (hist_r[idx][n_hist - 1 - j]) return rv;
        end
        return hist_d[idx][n_hist - stg];
    endfunction

    // One clock edge: record inputs at the edge, then check all instances.
    task automatic step();
        @(posedge clk);
        hist_d[0][n_hist] = 32'(if_a.d); hist_r[0][n_hist] = rst_a;
        hist_d[1][n_hist] = 32'(if_b.d); hist_r[1][n_hist] = rst_b;
        hist_d[2][n_hist] = if_c.d;      hist_r[2][n_hist] = rst_c;
        hist_d[3][n_hist] = 32'(if_d.d); hist_r[3][n_hist] = rst_d;
        n_hist++;
        #1;
        check_eq("a_model", 32'(if_a.q), model(0, 1, 32'h0000_0000));
        check_eq("b_model", 32'(if_b.q), model(1, 1, 32'h0000_00FF));
        check_eq("c_model", if_c.q,      model(2, 3, 32'h0000_0000));
        check_eq("d_model", 32'(if_d.q), model(3, 2, 32'h0000_0001));
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
        if_a.d = 8'hA5; if_b.d = 8'hA5; if_c.d = 32'h0; if_d.d = 1'b0;

        // Reset load over two edges, d ignored.
        step();
        check_eq("a_rst_edge1", 32'(if_a.q), 32'h00);
        check_eq("b_rst_edge1", 32'(if_b.q), 32'hFF);
        step();
        check_eq("a_rst_edge2", 32'(if_a.q), 32'h00);
        check_eq("c_rst_edge2", if_c.q, 32'h0);

        // Capture on first edge after release.
        rst_a = 1'b0; rst_b = 1'b0;
        if_a.d = 8'hA5; if_b.d = 8'h01;
        step();
        check_eq("a_capture_a5", 32'(if_a.q), 32'hA5);
        check_eq("b_capture_01", 32'(if_b.q), 32'h01);
        if_a.d = 8'h3C;
        step();
        check_eq("a_capture_3c", 32'(if_a.q), 32'h3C);
        #3;
        check_eq("a_stable_mid", 32'(if_a.q), 32'h3C);

        // Reset pulse strictly between edges has no effect.
        rst_a = 1'b1;
        #3;
        rst_a = 1'b0;
        #1;
        check_eq("a_pulse_noeff", 32'(if_a.q), 32'h3C);
        rst_a = 1'b1;
        #1;
        check_eq("a_rst_not_early", 32'(if_a.q), 32'h3C);
        step();
        check_eq("a_rst_at_edge", 32'(if_a.q), 32'h00);
        rst_a = 1'b0;

        // Three-stage pipeline latency.
        rst_c = 1'b0;
        if_c.d = 32'h1; step(); check_eq("c_lat_e1", if_c.q, 32'h0);
        if_c.d = 32'h2; step(); check_eq("c_lat_e2", if_c.q, 32'h0);
        if_c.d = 32'h3; step(); check_eq("c_lat_e3", if_c.q, 32'h1);
        if_c.d = 32'h4; step(); check_eq("c_lat_e4", if_c.q, 32'h2);
        if_c.d = 32'h5; step(); check_eq("c_lat_e5", if_c.q, 32'h3);

        // Mid-stream reset flushes everything in flight.
        rst_c = 1'b1;
        step(); check_eq("c_flush_edge", if_c.q, 32'h0);
        rst_c = 1'b0;
        if_c.d = 32'h6; step(); check_eq("c_flush_r1", if_c.q, 32'h0);
        if_c.d = 32'h7; step(); check_eq("c_flush_r2", if_c.q, 32'h0);
        if_c.d = 32'h8; step(); check_eq("c_flush_r3", if_c.q, 32'h6);

        // Randomised run on all widths with occasional resets.
        rst_d = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if_a.d = 8'($urandom);
            if_b.d = 8'($urandom);
            if_c.d = $urandom;
            if_d.d = 1'($urandom);
            rst_a = ($urandom_range(15) == 0);
            rst_b = ($urandom_range(15) == 0);
            rst_c = ($urandom_range(31) == 0);
            rst_d = ($urandom_range(31) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_flop_r
